// File: rtl/pixel_dispatcher.sv
// pixel_dispatcher: hands x coordinates of the current line to NUM_ENGINES external depth
// engines, collects their tagged results in per-engine hold registers and drains them through
// a round-robin arbiter onto a valid/ready output stream. Runs one line per start, or a whole
// frame with automatic line advance.
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   start, frame_mode      begin a line (frame_mode=0) or a frame (frame_mode=1), IDLE only
//   busy                   high outside IDLE
//   line_done, frame_done  one-cycle pulses when a line / the last line of a frame completes
//   eng_start, eng_x       per-engine dispatch pulse and x (x held until the next dispatch)
//   eng_y                  current line, shared by all engines
//   eng_done, eng_depth    per-engine completion pulse and depth result
//   out_valid/out_ready    result stream handshake, with out_x, out_y, out_depth
//   protocol_err           sticky: completion seen from an engine that was not busy
module pixel_dispatcher #(
  parameter int unsigned SCREEN_WIDTH  = 640,
  parameter int unsigned SCREEN_HEIGHT = 480,
  parameter int unsigned NUM_ENGINES   = 5,
  parameter int unsigned DEPTH_WIDTH   = 10,
  parameter int unsigned X_WIDTH       = $clog2(SCREEN_WIDTH),
  parameter int unsigned Y_WIDTH       = $clog2(SCREEN_HEIGHT)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               frame_mode,
  output logic                               busy,
  output logic                               line_done,
  output logic                               frame_done,
  output logic [NUM_ENGINES-1:0]             eng_start,
  output logic [NUM_ENGINES*X_WIDTH-1:0]     eng_x,
  output logic [Y_WIDTH-1:0]                 eng_y,
  input  logic [NUM_ENGINES-1:0]             eng_done,
  input  logic [NUM_ENGINES*DEPTH_WIDTH-1:0] eng_depth,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [X_WIDTH-1:0]                 out_x,
  output logic [Y_WIDTH-1:0]                 out_y,
  output logic [DEPTH_WIDTH-1:0]             out_depth,
  output logic                               protocol_err
);

  // next_x must be able to hold SCREEN_WIDTH itself, hence one extra bit.
  localparam int unsigned NX_W = X_WIDTH + 1;
  localparam int unsigned RR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

  localparam logic [NX_W-1:0]    X_END   = NX_W'(SCREEN_WIDTH);
  localparam logic [Y_WIDTH-1:0] Y_LAST  = Y_WIDTH'(SCREEN_HEIGHT - 1);
  localparam logic [RR_W-1:0]    RR_LAST = RR_W'(NUM_ENGINES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;
  typedef enum logic [1:0] {EngFree, EngBusy, EngHold} eng_state_e;

  state_e             state_q, state_d;
  eng_state_e         eng_st_q     [NUM_ENGINES];
  logic [X_WIDTH-1:0] x_q          [NUM_ENGINES];
  logic [X_WIDTH-1:0] hold_x_q     [NUM_ENGINES];
  logic [DEPTH_WIDTH-1:0] hold_depth_q [NUM_ENGINES];

  logic [NX_W-1:0]        next_x_q, next_x_d;
  logic [Y_WIDTH-1:0]     eng_y_q, eng_y_d;
  logic                   frame_mode_q;
  logic [RR_W-1:0]        rr_q;
  logic                   out_valid_q;
  logic [X_WIDTH-1:0]     out_x_q;
  logic [Y_WIDTH-1:0]     out_y_q;
  logic [DEPTH_WIDTH-1:0] out_depth_q;
  logic                   protocol_err_q;

  logic [NUM_ENGINES-1:0] is_free, is_busy, is_hold;
  logic                   dispatch_en;
  logic [RR_W-1:0]        dispatch_idx;
  logic                   sel_en;
  logic [RR_W-1:0]        sel_idx;
  logic                   out_load;
  logic                   drain_done;

  always_comb begin
    is_free = '0;
    is_busy = '0;
    is_hold = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      is_free[i] = (eng_st_q[i] == EngFree);
      is_busy[i] = (eng_st_q[i] == EngBusy);
      is_hold[i] = (eng_st_q[i] == EngHold);
    end
  end

  // Lowest-index free engine takes the next pixel, at most one per cycle.
  always_comb begin
    dispatch_en  = 1'b0;
    dispatch_idx = '0;
    if (state_q == StRun && next_x_q < X_END) begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
        if (!dispatch_en && is_free[i]) begin
          dispatch_en  = 1'b1;
          dispatch_idx = RR_W'(i);
        end
      end
    end
  end

  // Round-robin: first pass covers engines at or after the pointer, second pass wraps.
  always_comb begin
    sel_en  = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (!sel_en && is_hold[i] && RR_W'(i) >= rr_q) begin
        sel_en  = 1'b1;
        sel_idx = RR_W'(i);
      end
    end
    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (!sel_en && is_hold[i]) begin
        sel_en  = 1'b1;
        sel_idx = RR_W'(i);
      end
    end
  end

  assign out_load   = sel_en && (!out_valid_q || out_ready);
  assign drain_done = (state_q == StDrain) && (&is_free) && !out_valid_q;

  // Top FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Top FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (next_x_q == X_END) state_d = StDrain;
      StDrain: begin
        if (drain_done) begin
          state_d = (frame_mode_q && eng_y_q != Y_LAST) ? StRun : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Top FSM: outputs. eng_x bypasses next_x so the coordinate is valid with its pulse.
  always_comb begin
    busy       = (state_q != StIdle);
    line_done  = drain_done;
    frame_done = drain_done && (eng_y_q == Y_LAST);
    eng_start  = '0;
    eng_x      = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      eng_start[i] = dispatch_en && (dispatch_idx == RR_W'(i));
      eng_x[i*X_WIDTH +: X_WIDTH] = (dispatch_en && (dispatch_idx == RR_W'(i))) ?
                                    next_x_q[X_WIDTH-1:0] : x_q[i];
    end
  end

  // Line / pixel counters.
  always_comb begin
    next_x_d = next_x_q;
    eng_y_d  = eng_y_q;
    if (state_q == StIdle && start) begin
      next_x_d = '0;
    end else if (dispatch_en) begin
      next_x_d = next_x_q + NX_W'(1);
    end else if (drain_done) begin
      next_x_d = '0;
    end
    if (drain_done) begin
      eng_y_d = (eng_y_q == Y_LAST) ? '0 : eng_y_q + Y_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      next_x_q       <= '0;
      eng_y_q        <= '0;
      frame_mode_q   <= 1'b0;
      rr_q           <= '0;
      out_valid_q    <= 1'b0;
      out_x_q        <= '0;
      out_y_q        <= '0;
      out_depth_q    <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      next_x_q       <= next_x_d;
      eng_y_q        <= eng_y_d;
      protocol_err_q <= protocol_err_q | (|(eng_done & ~is_busy));
      if (state_q == StIdle && start) begin
        frame_mode_q <= frame_mode;
      end
      if (out_load) begin
        out_valid_q <= 1'b1;
        out_x_q     <= hold_x_q[sel_idx];
        out_y_q     <= eng_y_q;
        out_depth_q <= hold_depth_q[sel_idx];
        rr_q        <= (sel_idx == RR_LAST) ? '0 : sel_idx + RR_W'(1);
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Per-engine FREE -> BUSY -> HOLD -> FREE. A HOLD engine is only released by the arbiter,
  // so backpressure naturally stops dispatch to it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
        eng_st_q[i]     <= EngFree;
        x_q[i]          <= '0;
        hold_x_q[i]     <= '0;
        hold_depth_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
        case (eng_st_q[i])
          EngFree: begin
            if (dispatch_en && dispatch_idx == RR_W'(i)) begin
              eng_st_q[i] <= EngBusy;
              x_q[i]      <= next_x_q[X_WIDTH-1:0];
            end
          end
          EngBusy: begin
            if (eng_done[i]) begin
              eng_st_q[i]     <= EngHold;
              hold_x_q[i]     <= x_q[i];
              hold_depth_q[i] <= eng_depth[i*DEPTH_WIDTH +: DEPTH_WIDTH];
            end
          end
          EngHold: begin
            if (out_load && sel_idx == RR_W'(i)) begin
              eng_st_q[i] <= EngFree;
            end
          end
          default: eng_st_q[i] <= EngFree;
        endcase
      end
    end
  end

  assign eng_y        = eng_y_q;
  assign out_valid    = out_valid_q;
  assign out_x        = out_x_q;
  assign out_y        = out_y_q;
  assign out_depth    = out_depth_q;
  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Bench for pixel_dispatcher with 2 engines on an 8x2 screen. An engine model answers each
// dispatch after a per-engine latency; starting a line pushes its expected results into a
// scoreboard and a monitor removes each emitted result from it.
module tb_pixel_dispatcher;
  localparam int W  = 8;
  localparam int H  = 2;
  localparam int N  = 2;
  localparam int DW = 10;
  localparam int XW = 3;
  localparam int YW = 1;

  typedef struct {int x; int y; int d;} exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            frame_mode;
  logic            busy, line_done, frame_done;
  logic [N-1:0]    eng_start;
  logic [N*XW-1:0] eng_x;
  logic [YW-1:0]   eng_y;
  logic [N-1:0]    eng_done;
  logic [N*DW-1:0] eng_depth;
  logic            out_valid;
  logic            out_ready;
  logic [XW-1:0]   out_x;
  logic [YW-1:0]   out_y;
  logic [DW-1:0]   out_depth;
  logic            protocol_err;

  pixel_dispatcher #(
    .SCREEN_WIDTH (W),
    .SCREEN_HEIGHT(H),
    .NUM_ENGINES  (N),
    .DEPTH_WIDTH  (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .frame_mode  (frame_mode),
    .busy        (busy),
    .line_done   (line_done),
    .frame_done  (frame_done),
    .eng_start   (eng_start),
    .eng_x       (eng_x),
    .eng_y       (eng_y),
    .eng_done    (eng_done),
    .eng_depth   (eng_depth),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_depth   (out_depth),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   line_cnt = 0, frame_cnt = 0, out_cnt = 0, total_starts = 0, inv_cnt = 0;
  int   e_starts[N];
  int   lat[N];
  logic [N-1:0] spur = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int depth_of(input int x, input int y);
    return (x * 37 + y * 200 + 3) % 1024;
  endfunction

  // Engine model: answers eng_start[i] exactly lat[i] cycles later with depth_of(x, y).
  initial begin
    int cnt[N];
    int rx[N];
    int ry[N];
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      e_starts[i] = 0;
    end
    eng_done  = '0;
    eng_depth = '0;
    forever begin
      @(negedge clk);
      eng_done = '0;
      for (int i = 0; i < N; i++) begin
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            eng_done[i] = 1'b1;
            eng_depth[i*DW +: DW] = DW'(depth_of(rx[i], ry[i]));
          end
        end
      end
      eng_done = eng_done | spur;
      spur = '0;
      if (!reset) begin
        for (int i = 0; i < N; i++) begin
          if (eng_start[i]) begin
            cnt[i] = lat[i];
            rx[i]  = int'(eng_x[i*XW +: XW]);
            ry[i]  = int'(eng_y);
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted result, counts pulses and dispatches.
  initial begin
    int idx;
    int last_x;
    bit have_last;
    have_last = 1'b0;
    last_x = 0;
    forever begin
      @(negedge clk);
      #3;
      if (line_done) line_cnt++;
      if (frame_done) begin
        frame_cnt++;
        chk("frame_done_with_line_done", line_done, 1);
      end
      if (eng_start != '0) begin
        total_starts++;
        for (int i = 0; i < N; i++) if (eng_start[i]) e_starts[i]++;
        chk("one_dispatch_per_cycle", $countones(eng_start), 1);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        idx = -1;
        for (int k = 0; k < exp_q.size(); k++) begin
          if (idx < 0 && exp_q[k].x == int'(out_x) && exp_q[k].y == int'(out_y)) idx = k;
        end
        chk($sformatf("result_expected_x%0d_y%0d", out_x, out_y), idx >= 0, 1);
        if (idx >= 0) begin
          chk($sformatf("depth_x%0d_y%0d", out_x, out_y), out_depth, exp_q[idx].d);
          exp_q.delete(idx);
        end
        if (have_last && int'(out_x) < last_x) inv_cnt++;
        last_x = int'(out_x);
        have_last = 1'b1;
        out_cnt++;
      end
    end
  end

  // Queue the expected results, pulse start, check the first dispatch the following cycle.
  task automatic start_line(input int mode, input int y0);
    int nl;
    nl = (mode != 0) ? (H - y0) : 1;
    for (int l = 0; l < nl; l++)
      for (int x = 0; x < W; x++) exp_q.push_back('{x, y0 + l, depth_of(x, y0 + l)});
    @(negedge clk);
    start = 1'b1;
    frame_mode = (mode != 0);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("first_eng_start", eng_start, 1);
    chk("first_eng_x", eng_x[XW-1:0], 0);
    chk("start_eng_y", eng_y, y0);
  endtask

  task automatic wait_lines(input int target, input int budget);
    int n;
    n = 0;
    while (line_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("line_done_within_budget", line_cnt >= target, 1);
    @(negedge clk);
    #1;
  endtask

  initial begin
    int lc, fc, oc, st_mid, n;
    logic stable, sv;
    logic [XW-1:0] sx;
    logic [YW-1:0] sy;
    logic [DW-1:0] sd;

    reset = 1'b1; start = 1'b0; frame_mode = 1'b0; out_ready = 1'b1;
    lat[0] = 3; lat[1] = 3;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_line_done", line_done, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_eng_x", eng_x, 0);
    chk("rst_eng_y", eng_y, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_depth", out_depth, 0);
    chk("rst_protocol_err", protocol_err, 0);

    // Single line 0, then line 1 which completes the frame.
    lc = line_cnt; fc = frame_cnt; oc = out_cnt;
    start_line(0, 0);
    wait_lines(lc + 1, 300);
    chk("l0_lines", line_cnt - lc, 1);
    chk("l0_no_frame_done", frame_cnt - fc, 0);
    chk("l0_outputs", out_cnt - oc, W);
    chk("l0_busy_low", busy, 0);
    chk("l0_eng_y", eng_y, 1);
    chk("l0_sb_empty", exp_q.size(), 0);
    lc = line_cnt; fc = frame_cnt; oc = out_cnt;
    start_line(0, 1);
    wait_lines(lc + 1, 300);
    chk("l1_frame_done", frame_cnt - fc, 1);
    chk("l1_outputs", out_cnt - oc, W);
    chk("l1_eng_y_wrap", eng_y, 0);
    chk("l1_sb_empty", exp_q.size(), 0);

    // Whole frame from a single start.
    lc = line_cnt; fc = frame_cnt; oc = out_cnt;
    start_line(1, 0);
    wait_lines(lc + 2, 600);
    chk("fr_lines", line_cnt - lc, 2);
    chk("fr_frame_done", frame_cnt - fc, 1);
    chk("fr_outputs", out_cnt - oc, 2 * W);
    chk("fr_busy_low", busy, 0);
    chk("fr_eng_y", eng_y, 0);
    chk("fr_sb_empty", exp_q.size(), 0);

    // Backpressure: hold out_ready low for 30 cycles once a result is presented.
    lc = line_cnt; oc = out_cnt;
    start_line(0, 0);
    repeat (6) @(negedge clk);
    out_ready = 1'b0;
    n = 0;
    #1;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("stall_out_valid", out_valid, 1);
    sv = out_valid; sx = out_x; sy = out_y; sd = out_depth;
    stable = 1'b1;
    st_mid = total_starts;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (out_valid !== sv || out_x !== sx || out_y !== sy || out_depth !== sd) stable = 1'b0;
      if (i == 10) st_mid = total_starts;
    end
    chk("stall_outputs_stable", stable, 1);
    chk("stall_no_dispatch", total_starts - st_mid, 0);
    out_ready = 1'b1;
    wait_lines(lc + 1, 300);
    chk("bp_outputs", out_cnt - oc, W);
    chk("bp_sb_empty", exp_q.size(), 0);
    chk("bp_eng_y", eng_y, 1);

    // Unequal latencies: fast engine takes most pixels, results leave out of x order.
    lat[0] = 10; lat[1] = 2;
    lc = line_cnt; fc = frame_cnt; oc = out_cnt;
    e_starts[0] = 0; e_starts[1] = 0; inv_cnt = 0;
    start_line(0, 1);
    wait_lines(lc + 1, 300);
    chk("skew_outputs", out_cnt - oc, W);
    chk("skew_sb_empty", exp_q.size(), 0);
    chk("skew_fast_engine_more", e_starts[1] > e_starts[0], 1);
    chk("skew_out_of_order", inv_cnt > 0, 1);
    chk("skew_frame_done", frame_cnt - fc, 1);
    chk("skew_eng_y", eng_y, 0);

    // Start while busy is ignored; spurious completion sets the sticky error.
    lat[0] = 3; lat[1] = 3;
    lc = line_cnt;
    start_line(0, 0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("busy_while_running", busy, 1);
    wait_lines(lc + 1, 300);
    repeat (20) @(negedge clk);
    #1;
    chk("ignored_start_lines", line_cnt - lc, 1);
    chk("ignored_start_idle", busy, 0);
    chk("ignored_start_eng_y", eng_y, 1);
    chk("ignored_start_sb_empty", exp_q.size(), 0);
    chk("perr_clear", protocol_err, 0);
    spur = 2'b01;
    repeat (2) @(negedge clk);
    #1;
    chk("perr_set", protocol_err, 1);
    repeat (10) @(negedge clk);
    #1;
    chk("perr_sticky", protocol_err, 1);

    // Reset with both engines busy; their late completions must only flag an error.
    lat[0] = 6; lat[1] = 6;
    oc = out_cnt;
    start_line(0, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_eng_start", eng_start, 0);
    chk("mid_rst_eng_x", eng_x, 0);
    chk("mid_rst_eng_y", eng_y, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_protocol_err", protocol_err, 0);
    repeat (12) @(negedge clk);
    #1;
    chk("late_done_perr", protocol_err, 1);
    chk("late_done_no_output", out_cnt - oc, 0);
    lat[0] = 3; lat[1] = 3;
    lc = line_cnt; oc = out_cnt;
    start_line(0, 0);
    wait_lines(lc + 1, 300);
    chk("post_rst_outputs", out_cnt - oc, W);
    chk("post_rst_sb_empty", exp_q.size(), 0);
    chk("post_rst_eng_y", eng_y, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
